mo_line_buffer: RTL and testbench
=================================

Name: mo_line_buffer

Overview:
- Downstream of the motion-object playfield/address stage.
- Takes one 8-pixel, 4bpp graphics word per load, plus its start X, colour and H-flip. Writes the non-transparent pixels into a double-buffered 512-entry scanline buffer.
- The other buffer is read out to the video mixer at the current display H position, and each location is cleared as it is read.
- The two buffers swap roles on every LINE_SWAP pulse.

Parameters:
- HVISIBLE, 336, writes at X >= HVISIBLE are suppressed.
- XW, 9, X/H position width; buffer depth is 2^XW = 512 per bank.

Ports:
- MCKF  input  1  master pixel clock; all state changes on the rising edge.
- RESET  input  1  asynchronous active-high reset.
- LINE_SWAP  input  1  one-cycle pulse at scanline start; swaps the write and display banks.
- GLD_b  input  1  active-low graphics load request; sampled only while BUSY=0.
- GD  input  32  graphics word; pixel i = GD[31-4i : 28-4i], i=0..7.
- XPOS  input  9  X position of the leftmost pixel.
- COLOR  input  4  palette select for the word.
- HFLIP  input  1  horizontal flip for the word.
- HPOS  input  9  display read address.
- BUSY  output  1  word write or clear sweep in progress; loads are ignored.
- MOPIX  output  8  {colour, pixel} read from the display bank; 0 means transparent.
- WBANK  output  1  index of the current write bank.

Behaviour:
- Reset, asynchronous:
  - WBANK=0, MOPIX=0, BUSY=1, pixel counter=0.
  - The state machine enters CLEAR.
- CLEAR state:
  - Addresses 0..511 of both banks are written with 0, one address per cycle.
  - 512 cycles after RESET deasserts, BUSY=0 and the state becomes IDLE.
  - LINE_SWAP is ignored during CLEAR.
  - MOPIX is held at 0 during CLEAR.
- IDLE state:
  - GLD_b=0 at an edge accepts a load: GD, XPOS, COLOR and HFLIP are latched.
  - State becomes WRITE, counter k=0, BUSY=1 from the next cycle.
- WRITE state: one pixel per cycle for k=0..7.
  - Source pixel: i=k when HFLIP=0, i=7-k when HFLIP=1.
  - Address: X = (XPOS + k) mod 512.
  - Write {COLOR, pix_i} to the write bank at X only when pix_i != 0 and X < HVISIBLE. Later writes overwrite earlier ones.
  - After k=7, return to IDLE; BUSY=0 in the following cycle.
  - BUSY is high for exactly 8 cycles per word. The earliest next accept is the cycle BUSY=0 is first sampled.
- LINE_SWAP (outside CLEAR):
  - WBANK toggles on that edge.
  - Any in-progress WRITE is aborted: remaining pixels are discarded, the state becomes IDLE, and BUSY=0 the next cycle.
  - LINE_SWAP and GLD_b=0 on the same edge: the swap wins and the load is ignored.
- Display read, every cycle outside CLEAR:
  - MOPIX <= displaybank[HPOS], where displaybank = !WBANK, with 1-cycle latency.
  - The same edge writes 0 to displaybank[HPOS] (read-then-clear).
  - Reads on the edge of LINE_SWAP use the bank selected before the swap.
- The write and display banks never coincide, so there is no write/read address conflict.
- Wrap: XPOS + k beyond 511 wraps to 0; the HVISIBLE check is applied after the wrap.
- RESET mid-WRITE or mid-CLEAR restarts the full CLEAR sweep.

Test Plan:
- Reset then idle:
  - BUSY=1 for 512 cycles after RESET falls, then 0; MOPIX=0 throughout.
  - Read all of HPOS 0..511 on both banks → all return 0.
- Basic load:
  - GD=32'h12345678, XPOS=10, COLOR=4'hA, HFLIP=0; LINE_SWAP; read HPOS 10..17.
  - → MOPIX = A1, A2, …, A8, one cycle after each address.
  - Re-reading the same addresses on the next frame of that bank → 0 (cleared).
- Flip and transparency:
  - GD=32'h10000002, XPOS=100, COLOR=3, HFLIP=1; swap; read.
  - → X100=0x32, X107=0x31, X101..106=0 (untouched).
- Clip and wrap:
  - XPOS=330, GD=32'h11111111 → only X330..335 written; X336,337 stay 0.
  - XPOS=510, HVISIBLE=512 → writes land at X510, 511, 0..5.
- Swap abort:
  - LINE_SWAP asserted 3 cycles after accept → only pixels k=0..2 appear in the old bank.
  - BUSY=0 next cycle; WBANK toggles.
  - A simultaneous GLD_b=0 on the swap edge produces no write.
- Reset mid-write: RESET pulsed during WRITE → CLEAR sweep restarts; all addresses read 0 afterward.

Source files
------------

// File: rtl/mo_line_buffer_if.sv
// Motion-object line buffer bus: graphics-word load handshake, scanline swap,
// display read address and the mixer-facing pixel output.
interface mo_line_buffer_if #(
   parameter int XW = 9
);
   logic          LINE_SWAP;
   logic          GLD_b;
   logic [31:0]   GD;
   logic [XW-1:0] XPOS;
   logic [3:0]    COLOR;
   logic          HFLIP;
   logic [XW-1:0] HPOS;
   logic          BUSY;
   logic [7:0]    MOPIX;
   logic          WBANK;

   // Source side: the object stage and video timing that drive the buffer.
   modport master (
      output LINE_SWAP, GLD_b, GD, XPOS, COLOR, HFLIP, HPOS,
      input  BUSY, MOPIX, WBANK
   );

   // Buffer side.
   modport slave (
      input  LINE_SWAP, GLD_b, GD, XPOS, COLOR, HFLIP, HPOS,
      output BUSY, MOPIX, WBANK
   );
endinterface

// File: rtl/mo_line_buffer.sv
// Double-buffered motion-object scanline buffer. One bank collects the
// non-transparent pixels of 8-pixel graphics words for the next line while
// the other bank is streamed to the mixer and cleared behind the read.
module mo_line_buffer #(
   parameter int HVISIBLE = 336,
   parameter int XW       = 9
) (
   input  logic           MCKF,
   input  logic           RESET,
   mo_line_buffer_if.slave bus
);

   localparam int DEPTH = 1 << XW;

   typedef enum logic [1:0] {
      S_CLEAR,
      S_IDLE,
      S_WRITE
   } state_t;

   state_t        state_q;
   logic [XW-1:0] clr_cnt_q;
   logic [2:0]    k_q;
   logic [31:0]   gd_q;
   logic [XW-1:0] xpos_q;
   logic [3:0]    color_q;
   logic          hflip_q;
   logic          wbank_q;
   logic          busy_q;
   logic [7:0]    mopix_q;

   logic [7:0]    bank0_q [DEPTH];
   logic [7:0]    bank1_q [DEPTH];

   logic          swap;
   logic [2:0]    pix_sel;
   logic [3:0]    pix_val;
   logic [XW-1:0] pix_x;
   logic          pix_we;

   // Current pixel of the latched word, its wrapped address and write enable.
   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      swap    = bus.LINE_SWAP && (state_q != S_CLEAR);
      // Pixel i lives at GD[31-4i -: 4]; flipping walks i from 7 down (7-k == ~k).
      pix_sel = hflip_q ? ~k_q : k_q;
      pix_val = gd_q[{~pix_sel, 2'b00} +: 4];
      pix_x   = xpos_q + XW'(k_q);
      // A swap on this edge aborts the word, including the pixel due now.
      pix_we  = (state_q == S_WRITE) && !bus.LINE_SWAP && (pix_val != 4'd0)
                && (int'(pix_x) < HVISIBLE);
   end

   // Control FSM: clear sweep, load accept, pixel walk, bank swap and read register.
   // NOTE: sequential state uses non-blocking assignments only, so every register
   // sees the pre-edge value of every other register.
   always_ff @(posedge MCKF or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_CLEAR;
         clr_cnt_q <= '0;
         k_q       <= '0;
         gd_q      <= '0;
         xpos_q    <= '0;
         color_q   <= '0;
         hflip_q   <= 1'b0;
         wbank_q   <= 1'b0;
         busy_q    <= 1'b1;
         mopix_q   <= '0;
      end else begin
         case (state_q)
            S_CLEAR: begin
               mopix_q   <= '0;
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (clr_cnt_q == XW'(DEPTH - 1)) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               // Display bank is the one not being written; swap edge still
               // reads the bank selected before the swap.
               mopix_q <= wbank_q ? bank0_q[bus.HPOS] : bank1_q[bus.HPOS];
               if (swap) begin
                  wbank_q <= ~wbank_q;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  k_q     <= '0;
               end else if ((state_q == S_IDLE) && !bus.GLD_b) begin
                  gd_q    <= bus.GD;
                  xpos_q  <= bus.XPOS;
                  color_q <= bus.COLOR;
                  hflip_q <= bus.HFLIP;
                  k_q     <= '0;
                  state_q <= S_WRITE;
                  busy_q  <= 1'b1;
               end else if (state_q == S_WRITE) begin
                  k_q <= k_q + 1'b1;
                  if (k_q == 3'd7) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   // Line stores: sweep-clear, pixel write into the write bank, clear-behind-read
   // in the display bank.
   // NOTE: the stores have no reset; the CLEAR sweep zeroes them so they stay
   // mappable onto plain RAM.
   always_ff @(posedge MCKF) begin
      if (state_q == S_CLEAR) begin
         bank0_q[clr_cnt_q] <= '0;
         bank1_q[clr_cnt_q] <= '0;
      end else if (wbank_q) begin
         bank0_q[bus.HPOS] <= '0;
         if (pix_we) bank1_q[pix_x] <= {color_q, pix_val};
      end else begin
         bank1_q[bus.HPOS] <= '0;
         if (pix_we) bank0_q[pix_x] <= {color_q, pix_val};
      end
   end

   assign bus.BUSY  = busy_q;
   assign bus.MOPIX = mopix_q;
   assign bus.WBANK = wbank_q;

endmodule

// File: tb/tb_mo_line_buffer.sv
// Bench for mo_line_buffer: two instances (HVISIBLE 336 and 512) see identical
// stimulus; a bank model predicts each read, expectations go through a queue.
module tb_mo_line_buffer;

   localparam int XW   = 9;
   localparam int PARK = 300;   // idle read address, never written by any load

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          line_swap = 1'b0;
   logic          gld_b = 1'b1;
   logic [31:0]   gd = '0;
   logic [XW-1:0] xpos = '0;
   logic [3:0]    color = '0;
   logic          hflip = 1'b0;
   logic [XW-1:0] hpos = XW'(PARK);

   always #5 clk = ~clk;

   mo_line_buffer_if #(.XW(XW)) bus_a ();
   mo_line_buffer_if #(.XW(XW)) bus_w ();

   assign bus_a.LINE_SWAP = line_swap;
   assign bus_a.GLD_b     = gld_b;
   assign bus_a.GD        = gd;
   assign bus_a.XPOS      = xpos;
   assign bus_a.COLOR     = color;
   assign bus_a.HFLIP     = hflip;
   assign bus_a.HPOS      = hpos;
   assign bus_w.LINE_SWAP = line_swap;
   assign bus_w.GLD_b     = gld_b;
   assign bus_w.GD        = gd;
   assign bus_w.XPOS      = xpos;
   assign bus_w.COLOR     = color;
   assign bus_w.HFLIP     = hflip;
   assign bus_w.HPOS      = hpos;

   mo_line_buffer #(.HVISIBLE(336), .XW(XW)) dut_a (.MCKF(clk), .RESET(rst), .bus(bus_a));
   mo_line_buffer #(.HVISIBLE(512), .XW(XW)) dut_w (.MCKF(clk), .RESET(rst), .bus(bus_w));

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string      tag;
      logic [7:0] val;
   } sb_t;

   sb_t        sb_a[$];
   sb_t        sb_w[$];
   logic [7:0] model_mem [2][2][512];   // [instance][bank][x]
   int         hvis [2] = '{336, 512};
   logic       m_wbank = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_clear();
      for (int d = 0; d < 2; d++)
         for (int b = 0; b < 2; b++)
            for (int x = 0; x < 512; x++) model_mem[d][b][x] = 8'h00;
      m_wbank = 1'b0;
   endfunction

   // Reference pixel placement: first nk pixels of the word into the write bank.
   function automatic void model_write(input logic [31:0] w, input int x0,
                                       input logic [3:0] col, input logic flip, input int nk);
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < nk; k++) begin
            int         x;
            int         i;
            logic [3:0] p;
            x = (x0 + k) % 512;
            i = flip ? 7 - k : k;
            p = w[31 - 4*i -: 4];
            if (p != 4'd0 && x < hvis[d]) model_mem[d][int'(m_wbank)][x] = {col, p};
         end
   endfunction

   task automatic check_both_busy(input string tag, input logic exp);
      check({tag, "_a"}, 32'(bus_a.BUSY), 32'(exp));
      check({tag, "_w"}, 32'(bus_w.BUSY), 32'(exp));
   endtask

   // Present one read address, queue the expected pixel, compare after the edge.
   task automatic read_px(input int h, input string tag);
      sb_t e;
      hpos = XW'(h);
      sb_a.push_back('{tag: $sformatf("%s_a_x%0d", tag, h), val: model_mem[0][int'(!m_wbank)][h]});
      sb_w.push_back('{tag: $sformatf("%s_w_x%0d", tag, h), val: model_mem[1][int'(!m_wbank)][h]});
      model_mem[0][int'(!m_wbank)][h] = 8'h00;
      model_mem[1][int'(!m_wbank)][h] = 8'h00;
      tick();
      hpos = XW'(PARK);
      if (sb_a.size() > 0) begin
         e = sb_a.pop_front();
         check(e.tag, 32'(bus_a.MOPIX), 32'(e.val));
      end
      if (sb_w.size() > 0) begin
         e = sb_w.pop_front();
         check(e.tag, 32'(bus_w.MOPIX), 32'(e.val));
      end
   endtask

   task automatic read_range(input int lo, input int hi, input string tag);
      for (int h = lo; h <= hi; h++) read_px(h, tag);
   endtask

   task automatic do_swap(input string tag);
      line_swap = 1'b1;
      tick();
      line_swap = 1'b0;
      m_wbank = ~m_wbank;
      check({tag, "_wbank_a"}, 32'(bus_a.WBANK), 32'(m_wbank));
      check({tag, "_wbank_w"}, 32'(bus_w.WBANK), 32'(m_wbank));
   endtask

   task automatic drive_word(input logic [31:0] w, input int x0, input logic [3:0] col, input logic flip);
      gd    = w;
      xpos  = XW'(x0);
      color = col;
      hflip = flip;
   endtask

   // Full word load: BUSY must rise after the accept edge and stay high 8 cycles.
   task automatic load(input logic [31:0] w, input int x0, input logic [3:0] col,
                       input logic flip, input string tag);
      check_both_busy({tag, "_pre_busy"}, 1'b0);
      drive_word(w, x0, col, flip);
      gld_b = 1'b0;
      tick();
      gld_b = 1'b1;
      check_both_busy({tag, "_busy_rise"}, 1'b1);
      repeat (7) tick();
      check_both_busy({tag, "_busy_k7"}, 1'b1);
      tick();
      check_both_busy({tag, "_busy_fall"}, 1'b0);
      model_write(w, x0, col, flip, 8);
   endtask

   // Count cycles until both instances leave the clear sweep.
   task automatic wait_clear(input string tag);
      int n;
      n = 0;
      while ((bus_a.BUSY !== 1'b0 || bus_w.BUSY !== 1'b0) && n < 600) begin
         tick();
         n++;
      end
      check({tag, "_clear_len"}, 32'(n), 32'd512);
   endtask

   initial begin
      model_clear();
      #1 rst = 1'b1;
      tick();
      tick();
      check_both_busy("rst_busy", 1'b1);
      check("rst_mopix_a", 32'(bus_a.MOPIX), 32'h0);
      check("rst_wbank_a", 32'(bus_a.WBANK), 32'h0);
      check("rst_wbank_w", 32'(bus_w.WBANK), 32'h0);
      rst = 1'b0;

      // Clear sweep: BUSY high through edge 511, low after edge 512, swap ignored.
      for (int n = 1; n <= 512; n++) begin
         if (n == 100) line_swap = 1'b1;
         tick();
         line_swap = 1'b0;
         check_both_busy($sformatf("clear_busy_e%0d", n), (n < 512) ? 1'b1 : 1'b0);
         check($sformatf("clear_mopix_e%0d", n), 32'(bus_a.MOPIX), 32'h0);
         if (n == 100) check("clear_swap_ignored", 32'(bus_a.WBANK), 32'h0);
      end

      // Both banks read back all-zero after the sweep.
      read_range(0, 511, "clr_b1");
      do_swap("clr_sw1");
      read_range(0, 511, "clr_b0");
      do_swap("clr_sw2");

      // Basic load, then read-then-clear on the following frame of that bank.
      load(32'h12345678, 10, 4'hA, 1'b0, "basic");
      do_swap("basic_sw");
      read_range(9, 18, "basic_rd");
      do_swap("basic_sw2");
      do_swap("basic_sw3");
      read_range(10, 17, "basic_reread");

      // Flip with transparent interior pixels.
      load(32'h10000002, 100, 4'h3, 1'b1, "flip");
      do_swap("flip_sw");
      read_range(100, 107, "flip_rd");

      // Clip at HVISIBLE and wrap past 511 (the 512 instance keeps all pixels).
      load(32'h11111111, 330, 4'h5, 1'b0, "clip");
      load(32'h11111111, 510, 4'h6, 1'b0, "wrap");
      do_swap("clip_sw");
      read_range(328, 339, "clip_rd");
      read_range(508, 511, "wrap_hi");
      read_range(0, 7, "wrap_lo");

      // Swap three pixels into a word; a load on the swap edge is dropped.
      check_both_busy("abort_pre_busy", 1'b0);
      drive_word(32'h87654321, 200, 4'h7, 1'b0);
      gld_b = 1'b0;
      tick();
      gld_b = 1'b1;
      check_both_busy("abort_busy_rise", 1'b1);
      repeat (3) tick();
      model_write(32'h87654321, 200, 4'h7, 1'b0, 3);
      drive_word(32'hFFFFFFFF, 250, 4'h9, 1'b0);
      gld_b = 1'b0;
      do_swap("abort_sw");
      gld_b = 1'b1;
      check_both_busy("abort_busy_fall", 1'b0);
      tick();
      check_both_busy("abort_load_ignored", 1'b0);
      read_range(198, 210, "abort_rd");
      do_swap("abort_sw2");
      read_range(250, 257, "ignored_rd");

      // Reset in the middle of a word restarts the full sweep.
      drive_word(32'hFFFFFFFF, 20, 4'hC, 1'b0);
      gld_b = 1'b0;
      tick();
      gld_b = 1'b1;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      check_both_busy("midrst_busy", 1'b1);
      check("midrst_mopix_a", 32'(bus_a.MOPIX), 32'h0);
      check("midrst_wbank_a", 32'(bus_a.WBANK), 32'h0);
      tick();
      rst = 1'b0;
      model_clear();
      wait_clear("midrst");
      read_range(0, 511, "midrst_b1");
      do_swap("midrst_sw");
      read_range(0, 511, "midrst_b0");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
